// File: rtl/int_ctrl_defs.sv
// Shared int_ctrl definitions: source count, register offsets, cause codes.
// Mirrors the values software headers use for the interrupt controller.
package int_ctrl_defs;

  localparam int unsigned N_SRC = 6;

  // Word offsets decoded from ADDR[3:2]
  typedef enum logic [1:0] {
    RegPending = 2'd0,
    RegMask    = 2'd1,
    RegEdge    = 2'd2,
    RegCause   = 2'd3
  } reg_addr_e;

  localparam logic [31:0] CauseRam      = 32'd0;
  localparam logic [31:0] CauseDisk     = 32'd1;
  localparam logic [31:0] CauseVram     = 32'd2;
  localparam logic [31:0] CauseKeyboard = 32'd3;
  localparam logic [31:0] CauseCounter  = 32'd4;
  localparam logic [31:0] CauseSwitch   = 32'd5;

  // Index of the lowest set bit (0 when none); low index is highest priority.
  function automatic logic [31:0] lowest_set(input logic [31:0] vec);
    lowest_set = '0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) lowest_set = 32'(i);
    end
  endfunction

endpackage

// File: rtl/int_sync_edge.sv
// One-bit 2-flop synchroniser followed by a delay flop for rising-edge detection.
module int_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise
);

  logic meta_q, sync_q, dly_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      dly_q  <= 1'b0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign sync = sync_q;
  assign rise = sync_q & ~dly_q;

endmodule

// File: rtl/int_ctrl.sv
// Wishbone interrupt controller: pending/mask/edge registers, prioritised
// registered INT and CAUSE outputs.
module int_ctrl
  import int_ctrl_defs::*;
#(
  parameter int unsigned N_SRC = int_ctrl_defs::N_SRC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq,
  input  logic             STB,
  input  logic             WE,
  input  logic [31:0]      ADDR,
  input  logic [31:0]      DAT_I,
  output logic [31:0]      DAT_O,
  output logic             ACK,
  output logic             INT,
  output logic [31:0]      CAUSE
);

  logic [N_SRC-1:0] sync, rise;
  logic [N_SRC-1:0] pending_q, pending_d, mask_q, edge_q;
  logic [N_SRC-1:0] set_bits, clr_bits, qualified;
  logic             ack_q, int_q, wr_en, rd_en;
  logic [31:0]      dat_o_q, cause_q, rd_data;
  reg_addr_e        reg_sel;

  for (genvar g = 0; g < int'(N_SRC); g++) begin : g_sync
    int_sync_edge u_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (irq[g]),
      .sync (sync[g]),
      .rise (rise[g])
    );
  end

  assign reg_sel = reg_addr_e'(ADDR[3:2]);
  // Only the first cycle of a strobe is a bus beat; ACK blocks the repeat.
  assign wr_en   = STB & WE & ~ack_q;
  assign rd_en   = STB & ~ack_q;

  always_comb begin
    set_bits = (edge_q & rise) | (~edge_q & sync);
    clr_bits = '0;
    if (wr_en && reg_sel == RegPending) clr_bits = DAT_I[N_SRC-1:0];
    // Set after clear so a simultaneous set wins
    pending_d = (pending_q & ~clr_bits) | set_bits;
    qualified = pending_q & mask_q;
    rd_data   = '0;
    unique case (reg_sel)
      RegPending: rd_data = {{(32-N_SRC){1'b0}}, pending_q};
      RegMask:    rd_data = {{(32-N_SRC){1'b0}}, mask_q};
      RegEdge:    rd_data = {{(32-N_SRC){1'b0}}, edge_q};
      RegCause:   rd_data = cause_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      mask_q    <= '0;
      edge_q    <= '1;
      ack_q     <= 1'b0;
      int_q     <= 1'b0;
      cause_q   <= '0;
      dat_o_q   <= '0;
    end else begin
      pending_q <= pending_d;
      if (wr_en && reg_sel == RegMask) mask_q <= DAT_I[N_SRC-1:0];
      if (wr_en && reg_sel == RegEdge) edge_q <= DAT_I[N_SRC-1:0];
      ack_q     <= STB & ~ack_q;
      if (rd_en) dat_o_q <= rd_data;
      int_q     <= |qualified;
      cause_q   <= lowest_set({{(32-N_SRC){1'b0}}, qualified});
    end
  end

  assign DAT_O = dat_o_q;
  assign ACK   = ack_q;
  assign INT   = int_q;
  assign CAUSE = cause_q;

  logic unused_bits;
  assign unused_bits = ^{ADDR[31:4], ADDR[1:0], DAT_I[31:N_SRC]};

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter: N_SRC, 6, number of interrupt sources; bit i = cause code i (0 Ram, 1 Disk, 2 VRam, 3 Keyboard, 4 Counter, 5 Switch).
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  system clock (clk100 domain).
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 irq  input  N_SRC  raw device interrupt requests; asynchronous to clk.
REQ-006 STB  input  1  Wishbone strobe from intercon slot.
REQ-007 WE  input  1  Wishbone write enable.
REQ-008 ADDR  input  32  byte address; only ADDR[3:2] decoded.
REQ-009 DAT_I  input  32  write data.
REQ-010 DAT_O  output  32  read data.
REQ-011 ACK  output  1  Wishbone acknowledge.
REQ-012 INT  output  1  interrupt request to CPU.
REQ-013 CAUSE  output  32  cause code presented to CPU with INT.

Function
REQ-014 Each irq bit SHALL pass through a 2-flop synchroniser, then a delay flop for edge detection.
REQ-015 Register map (ADDR[3:2]): 0 PENDING (R, write-1-to-clear), 1 MASK (RW), 2 EDGE (RW; 1 = edge-triggered, 0 = level), 3 CAUSE (R; writes ignored).
REQ-016 Edge source i: pending[i] SHALL set on the cycle the synchronised input is 1 and its delayed copy is 0.
REQ-017 Level source i: pending[i] SHALL set on every cycle the synchronised input is 1.
REQ-018 Latency: irq[i] sampled high at edge k -> pending[i] = 1 after edge k+2 -> INT = 1 after edge k+3.
REQ-019 A W1C write SHALL clear the pending bits whose DAT_I bits are 1. If a set and a clear hit the same bit in the same cycle, set wins.
REQ-020 Bits of PENDING, MASK and EDGE at or above N_SRC SHALL read 0 and ignore writes.
REQ-021 INT SHALL be a register loaded each cycle with |(pending & mask).
REQ-022 CAUSE SHALL be a register loaded each cycle with the lowest index i for which pending[i] & mask[i] = 1, zero-extended to 32 bits. It SHALL be 0 when no bit qualifies. Lowest index is highest priority.
REQ-023 ACK SHALL be registered: ack <= STB & ~ack. This gives a one-cycle pulse one cycle after STB rises, repeating every second cycle while STB is held.
REQ-024 Writes SHALL take effect only on the cycle where STB & WE & ~ack; exactly one write per ACK pulse.
REQ-025 DAT_O SHALL be registered, loaded with the addressed register on STB & ~ack, and valid while ACK = 1. It SHALL hold its value otherwise.
REQ-026 A read of PENDING SHALL have no side effects.
REQ-027 Clearing MASK[i] while pending[i] = 1 SHALL drop INT on the next cycle (if no other bit qualifies) and SHALL leave pending[i] set.

Reset
REQ-028 While rst = 1 on a clock edge: synchronisers, delay flops, PENDING, MASK = 0; EDGE = all ones (bits < N_SRC); INT = 0; CAUSE = 0; ACK = 0; DAT_O = 0.
REQ-029 A reset asserted mid-transfer SHALL drop ACK on the next edge and discard the write. No pending state survives reset.
REQ-030 An irq held high through reset release SHALL set pending (edge mode) exactly once, 2 cycles after release.

Structure
REQ-031 A shared definitions file int_ctrl_defs SHALL hold N_SRC, the register offsets and the cause-code constants (shared with the top level and software headers).
REQ-032 One sub-module, int_sync_edge (2-flop sync + delay flop + rise output, 1 bit, replicated N_SRC times), SHALL be used.
REQ-033 No latches and no combinational path from irq to INT or CAUSE.

Verification
REQ-034 Reset, write MASK = 0x08, pulse irq[3] for 1 cycle -> pending = 0x08 after 2 cycles, INT = 1 and CAUSE = 3 one cycle later. Write 0x08 to PENDING -> INT = 0 two cycles after the ACK.
REQ-035 MASK = 0x3F, raise irq[1] and irq[4] together -> CAUSE = 1. W1C 0x02 -> CAUSE = 4 and INT stays 1. W1C 0x10 -> INT = 0.
REQ-036 EDGE = 0x00, hold irq[2] high, W1C 0x04 -> pending[2] reads 1 again on the next read. Drop irq[2], then W1C -> stays 0.
REQ-037 Hold STB = 1, WE = 1 to MASK for 6 cycles -> ACK pulses on cycles 2, 4, 6; the write is applied 3 times; no ACK occurs on consecutive cycles.
REQ-038 Same-cycle edge on irq[0] and W1C of bit 0 -> pending[0] = 1 afterwards. Assert rst during an ACK cycle -> ACK = 0, MASK = 0, INT = 0 next edge.
